// File: rtl/arb_req_agent.sv
// -----------------------------------------------------------------------------
// arb_req_agent
//
// Requester-side agent for one port of a round-robin arbiter. Upstream payloads
// are buffered in a small FIFO. A request is raised toward the arbiter while
// the FIFO holds anything. Each grant pulse pops exactly one payload, which is
// presented on o_data with a one-cycle o_data_vld pulse on the following cycle.
// A wait counter flags starvation, and a sticky flag records grants that
// arrive while the queue is empty.
//
// Parameters
//   DATA_W   width of one payload
//   DEPTH    FIFO entries (power of two, >= 2)
//   TIMEOUT  waiting cycles before o_starve is raised (>= 1)
//
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_wr_vld    upstream payload offered
//   i_wr_data   upstream payload
//   o_wr_rdy    FIFO can accept a payload (level < DEPTH)
//   o_req       request line to the arbiter (level != 0)
//   i_grant     registered one-cycle grant pulse from the arbiter
//   o_data_vld  one-cycle pulse, granted payload on o_data
//   o_data      granted payload, held between pulses
//   o_level     FIFO occupancy
//   o_starve    request pending TIMEOUT cycles without a grant
//   o_spurious  sticky: grant seen while the FIFO was empty
// -----------------------------------------------------------------------------
module arb_req_agent #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wr_vld,
    input  logic [DATA_W-1:0]          i_wr_data,
    output logic                       o_wr_rdy,
    output logic                       o_req,
    input  logic                       i_grant,
    output logic                       o_data_vld,
    output logic [DATA_W-1:0]          o_data,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_starve,
    output logic                       o_spurious
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;
    logic [CW-1:0]     wait_cnt;
    logic              spurious;
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;

    logic push;
    logic pop;

    assign o_wr_rdy = (level < FULL_LVL);
    assign o_req    = (level != '0);

    // A full FIFO drops offers, so a grant on a full cycle pops only.
    assign push = i_wr_vld && o_wr_rdy;
    assign pop  = i_grant && o_req;

    // Storage carries no reset; pointers and level define what is valid.
    always_ff @(posedge i_clk) begin
        if (push && i_rst_n) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            wait_cnt <= '0;
            spurious <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            // A grant with a request present is always a pop, so the counter
            // only advances on cycles where the request waits unserved.
            if (pop || !o_req) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + CW'(1);
            end

            if (i_grant && !o_req) begin
                spurious <= 1'b1;
            end
        end
    end

    // ---- stage p1: granted payload, one cycle after the grant ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= pop;
            if (pop) begin
                data_p1 <= mem[rd_ptr];
            end
        end
    end

    assign o_data_vld = vld_p1;
    assign o_data     = data_p1;
    assign o_level    = level;
    assign o_starve   = (wait_cnt == WAIT_MAX);
    assign o_spurious = spurious;

endmodule

// File: tb/tb_arb_req_agent.sv
// -----------------------------------------------------------------------------
// tb_arb_req_agent
//
// Directed bench for arb_req_agent (DATA_W=8, DEPTH=4, TIMEOUT=15). A table of
// per-cycle vectors drives inputs and lists the outputs expected after the
// following rising edge; hand-written sequences cover starvation and
// asynchronous reset assertion.
// -----------------------------------------------------------------------------
module tb_arb_req_agent;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic             clk;
    logic             rst_n;
    logic             wr_vld;
    logic [DATA_W-1:0] wr_data;
    logic             wr_rdy;
    logic             req;
    logic             grant;
    logic             data_vld;
    logic [DATA_W-1:0] data;
    logic [2:0]       level;
    logic             starve;
    logic             spurious;

    int checks   = 0;
    int failures = 0;

    arb_req_agent #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_vld  (wr_vld),
        .i_wr_data (wr_data),
        .o_wr_rdy  (wr_rdy),
        .o_req     (req),
        .i_grant   (grant),
        .o_data_vld(data_vld),
        .o_data    (data),
        .o_level   (level),
        .o_starve  (starve),
        .o_spurious(spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       wr_vld;
        logic [7:0] wr_data;
        logic       grant;
        logic       rdy;
        logic       req;
        logic       dvld;
        logic [7:0] data;
        logic [2:0] level;
        logic       starve;
        logic       spur;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [7:0] d, input logic g,
                       input logic e_rdy, input logic e_req, input logic e_dv,
                       input logic [7:0] e_d, input logic [2:0] e_lvl,
                       input logic e_st, input logic e_sp);
        vec_t x;
        x.rst_n = r; x.wr_vld = v; x.wr_data = d; x.grant = g;
        x.rdy = e_rdy; x.req = e_req; x.dvld = e_dv; x.data = e_d;
        x.level = e_lvl; x.starve = e_st; x.spur = e_sp;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [%0d] got=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic e_rdy,
                             input logic e_req, input logic e_dv, input logic [7:0] e_d,
                             input logic [2:0] e_lvl, input logic e_st, input logic e_sp);
        check({tag, ".wr_rdy"},   idx, 32'(wr_rdy),   32'(e_rdy));
        check({tag, ".req"},      idx, 32'(req),      32'(e_req));
        check({tag, ".data_vld"}, idx, 32'(data_vld), 32'(e_dv));
        check({tag, ".data"},     idx, 32'(data),     32'(e_d));
        check({tag, ".level"},    idx, 32'(level),    32'(e_lvl));
        check({tag, ".starve"},   idx, 32'(starve),   32'(e_st));
        check({tag, ".spurious"}, idx, 32'(spurious), 32'(e_sp));
    endtask

    initial begin
        // Fields: rst_n wr_vld wr_data grant | rdy req dvld data level starve spur
        // Three pushes, grants at cycles 5, 7, 9; data one cycle after each grant.
        add(1,1,8'hA1,0, 1,1,0,8'h00,3'd1,0,0);
        add(1,1,8'hA2,0, 1,1,0,8'h00,3'd2,0,0);
        add(1,1,8'hA3,0, 1,1,0,8'h00,3'd3,0,0);
        add(1,0,8'h00,0, 1,1,0,8'h00,3'd3,0,0);
        add(1,0,8'h00,1, 1,1,1,8'hA1,3'd2,0,0);
        add(1,0,8'h00,0, 1,1,0,8'hA1,3'd2,0,0);
        add(1,0,8'h00,1, 1,1,1,8'hA2,3'd1,0,0);
        add(1,0,8'h00,0, 1,1,0,8'hA2,3'd1,0,0);
        add(1,0,8'h00,1, 1,0,1,8'hA3,3'd0,0,0);
        add(1,0,8'h00,0, 1,0,0,8'hA3,3'd0,0,0);
        // Fill to DEPTH, offer 0xFF while full, then pop with 0xFF still offered.
        add(1,1,8'hB1,0, 1,1,0,8'hA3,3'd1,0,0);
        add(1,1,8'hB2,0, 1,1,0,8'hA3,3'd2,0,0);
        add(1,1,8'hB3,0, 1,1,0,8'hA3,3'd3,0,0);
        add(1,1,8'hB4,0, 0,1,0,8'hA3,3'd4,0,0);
        add(1,1,8'hFF,0, 0,1,0,8'hA3,3'd4,0,0);
        add(1,1,8'hFF,0, 0,1,0,8'hA3,3'd4,0,0);
        add(1,1,8'hFF,1, 1,1,1,8'hB1,3'd3,0,0);
        add(1,0,8'h00,1, 1,1,1,8'hB2,3'd2,0,0);
        add(1,0,8'h00,1, 1,1,1,8'hB3,3'd1,0,0);
        add(1,0,8'h00,1, 1,0,1,8'hB4,3'd0,0,0);
        add(1,0,8'h00,0, 1,0,0,8'hB4,3'd0,0,0);
        // Level 2, then six simultaneous push+grant cycles across pointer wrap.
        add(1,1,8'hC0,0, 1,1,0,8'hB4,3'd1,0,0);
        add(1,1,8'hC1,0, 1,1,0,8'hB4,3'd2,0,0);
        for (int i = 0; i < 6; i++) begin
            add(1,1,8'(8'hC2 + i),1, 1,1,1,8'(8'hC0 + i),3'd2,0,0);
        end
        add(1,0,8'h00,1, 1,1,1,8'hC6,3'd1,0,0);
        add(1,0,8'h00,1, 1,0,1,8'hC7,3'd0,0,0);
        add(1,0,8'h00,0, 1,0,0,8'hC7,3'd0,0,0);
        // Grant on empty queue: no pop, no pulse, sticky spurious flag.
        add(1,0,8'h00,1, 1,0,0,8'hC7,3'd0,0,1);
        add(1,0,8'h00,0, 1,0,0,8'hC7,3'd0,0,1);
        add(1,1,8'hD1,0, 1,1,0,8'hC7,3'd1,0,1);
        add(1,0,8'h00,1, 1,0,1,8'hD1,3'd0,0,1);
        // Three queued, one reset cycle with write and grant active, then grants.
        add(1,1,8'hE1,0, 1,1,0,8'hD1,3'd1,0,1);
        add(1,1,8'hE2,0, 1,1,0,8'hD1,3'd2,0,1);
        add(1,1,8'hE3,0, 1,1,0,8'hD1,3'd3,0,1);
        add(0,1,8'hEE,1, 1,0,0,8'h00,3'd0,0,0);
        add(1,0,8'h00,1, 1,0,0,8'h00,3'd0,0,1);
        add(1,0,8'h00,1, 1,0,0,8'h00,3'd0,0,1);
        add(1,0,8'h00,0, 1,0,0,8'h00,3'd0,0,1);
        add(0,0,8'h00,0, 1,0,0,8'h00,3'd0,0,0);

        // Reset state.
        rst_n = 1'b0; wr_vld = 1'b0; wr_data = '0; grant = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 0, 1,0,0,8'h00,3'd0,0,0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n   = vecs[i].rst_n;
            wr_vld  = vecs[i].wr_vld;
            wr_data = vecs[i].wr_data;
            grant   = vecs[i].grant;
            @(posedge clk);
            #1;
            check_all("vec", i, vecs[i].rdy, vecs[i].req, vecs[i].dvld, vecs[i].data,
                      vecs[i].level, vecs[i].starve, vecs[i].spur);
        end

        // Starvation: one entry waits TIMEOUT cycles, then a grant clears it.
        rst_n = 1'b1; wr_vld = 1'b1; wr_data = 8'h5A; grant = 1'b0;
        @(posedge clk); #1;
        wr_vld = 1'b0; wr_data = '0;
        check("starve.idle0", 0, 32'(starve), 32'd0);
        for (int j = 1; j <= TIMEOUT; j++) begin
            @(posedge clk); #1;
            check("starve.wait", j, 32'(starve), (j == TIMEOUT) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        check("starve.hold", 0, 32'(starve), 32'd1);
        grant = 1'b1;
        @(posedge clk); #1;
        grant = 1'b0;
        check_all("starve.grant", 0, 1,0,1,8'h5A,3'd0,0,0);

        // Asynchronous reset: takes effect without a clock edge.
        wr_vld = 1'b1; wr_data = 8'h77;
        @(posedge clk); #1;
        wr_data = 8'h78;
        @(posedge clk); #1;
        wr_vld = 1'b0;
        check("async.level_pre", 0, 32'(level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async", 0, 1,0,0,8'h00,3'd0,0,0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        grant = 1'b1;
        @(posedge clk); #1;
        grant = 1'b0;
        check("async.no_vld", 0, 32'(data_vld), 32'd0);
        check("async.level", 0, 32'(level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
